// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and frame/counter constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEFAULT_BAUD_RATE_NUMBER = 20;
  localparam int DATA_BITS                = 8;
  localparam int COUNTER_WIDTH            = 14;
  localparam int BIT_INDEX_WIDTH          = 3;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Loadable down-counter that times one UART bit; pulses o_bit_end on the last cycle of each bit.
module uart_tx_bit_timer #(
  parameter int BAUD_RATE_NUMBER = uart_pkg::DEFAULT_BAUD_RATE_NUMBER
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_bit_end
);
  import uart_pkg::*;

  localparam logic [COUNTER_WIDTH-1:0] RELOAD = COUNTER_WIDTH'(BAUD_RATE_NUMBER - 1);

  logic [COUNTER_WIDTH-1:0] r_count;

  assign o_bit_end = i_enable && (r_count == '0);

  // Reloading on zero instead of decrementing keeps the counter from ever wrapping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RELOAD;
    end else if (i_load || o_bit_end) begin
      r_count <= RELOAD;
    end else if (i_enable) begin
      r_count <= r_count - COUNTER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: valid/ready byte intake, LSB-first serialisation, registered line output.
module uart_transmitter #(
  parameter int BAUD_RATE_NUMBER = uart_pkg::DEFAULT_BAUD_RATE_NUMBER,
  parameter int DATA_BITS        = uart_pkg::DATA_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  import uart_pkg::*;

  localparam logic [BIT_INDEX_WIDTH-1:0] LAST_BIT = BIT_INDEX_WIDTH'(DATA_BITS - 1);

  state_t                     r_state;
  state_t                     w_state_next;
  logic [DATA_BITS-1:0]       r_shift;
  logic [DATA_BITS-1:0]       w_shift_next;
  logic [BIT_INDEX_WIDTH-1:0] r_bit_idx;
  logic [BIT_INDEX_WIDTH-1:0] w_bit_idx_next;
  logic                       r_tx_out;
  logic                       w_tx_out_next;
  logic                       w_accept;
  logic                       w_timer_enable;
  logic                       w_bit_end;

  assign w_accept       = (r_state == IDLE) && tx_valid;
  assign w_timer_enable = (r_state != IDLE);

  uart_tx_bit_timer #(
    .BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)
  ) u_bit_timer (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_enable (w_timer_enable),
    .o_bit_end(w_bit_end)
  );

  // NOTE: the shift register is ordinary flops, not a memory, so it is reset with the control state.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx_out  <= w_tx_out_next;
    end
  end

  // NOTE: hold-value defaults come first so every path assigns every signal and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next   = START;
          w_shift_next   = tx_data;
          w_bit_idx_next = '0;
        end
      end
      START: begin
        if (w_bit_end) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == LAST_BIT) begin
            w_state_next   = STOP;
            w_bit_idx_next = '0;
          end else begin
            w_bit_idx_next = r_bit_idx + BIT_INDEX_WIDTH'(1);
          end
        end
      end
      STOP: begin
        if (w_bit_end) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // The line value is derived from the next state so the registered output lines up with the state.
  always_comb begin
    w_tx_out_next = 1'b1;
    unique case (w_state_next)
      START:   w_tx_out_next = 1'b0;
      DATA:    w_tx_out_next = w_shift_next[0];
      default: w_tx_out_next = 1'b1;
    endcase
    tx_ready = (r_state == IDLE);
    tx_busy  = ~tx_ready;
    tx_done  = (r_state == STOP) && w_bit_end;
  end

  assign tx_out = r_tx_out;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench: frame-level line model for the N=20 instance, plus N=2 and N=16383 instances.
module tb_uart_transmitter;

  localparam int N       = 20;
  localparam int N_SMALL = 2;
  localparam int N_BIG   = 16383;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst_n   = 1'b1, tx_valid   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_out, tx_busy, tx_done;
  logic       rst_n_s = 1'b1, tx_valid_s = 1'b0;
  logic [7:0] tx_data_s = 8'h00;
  logic       tx_ready_s, tx_out_s, tx_busy_s, tx_done_s;
  logic       rst_n_b = 1'b1, tx_valid_b = 1'b0;
  logic [7:0] tx_data_b = 8'h00;
  logic       tx_ready_b, tx_out_b, tx_busy_b, tx_done_b;

  uart_transmitter #(.BAUD_RATE_NUMBER(N)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done));

  uart_transmitter #(.BAUD_RATE_NUMBER(N_SMALL)) dut_s (
    .clk_in(clk_in), .rst_n(rst_n_s), .tx_data(tx_data_s), .tx_valid(tx_valid_s),
    .tx_ready(tx_ready_s), .tx_out(tx_out_s), .tx_busy(tx_busy_s), .tx_done(tx_done_s));

  uart_transmitter #(.BAUD_RATE_NUMBER(N_BIG)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_out(tx_out_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b));

  wire rx_line [3];
  wire rx_done [3];
  assign rx_line[0] = tx_out;
  assign rx_line[1] = tx_out_s;
  assign rx_line[2] = tx_out_b;
  assign rx_done[0] = tx_done;
  assign rx_done[1] = tx_done_s;
  assign rx_done[2] = tx_done_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Line value k cycles after acceptance (k=1 is the first start-bit cycle).
  function automatic logic exp_line(input logic [7:0] b, input int k, input int n);
    if (k <= n) return 1'b0;
    if (k <= 9 * n) return b[(k - n - 1) / n];
    return 1'b1;
  endfunction

  // Frame-level model of the N=20 instance: busy for 10*N cycles after each acceptance.
  bit         m_busy = 1'b0;
  int         m_k    = 0;
  logic [7:0] m_byte = 8'h00;
  bit         cmp_en = 1'b0;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k == 10 * N + 1) m_busy = 1'b0;
    end else if (tx_valid === 1'b1) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_byte = tx_data;
    end
  end

  always @(negedge clk_in) begin
    if (cmp_en && rst_n) begin
      check("model tx_out", 32'(tx_out), 32'(m_busy ? exp_line(m_byte, m_k, N) : 1'b1));
      check("model tx_ready", 32'(tx_ready), 32'(!m_busy));
      check("model tx_busy", 32'(tx_busy), 32'(m_busy));
      check("model tx_done", 32'(tx_done), 32'(m_busy && (m_k == 10 * N)));
    end
  end

  // Receiver: finds the start edge, samples mid-bit, reports the cycle at which tx_done fired.
  task automatic rx_decode(input int idx, input int n, input int bound,
                           output logic [7:0] data, output int done_at);
    bit         found = 1'b0;
    logic [9:0] bits  = '0;
    data    = 8'h00;
    done_at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (rx_line[idx] === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("rx start edge found", 32'(found), 32'd1);
    if (!found) return;
    for (int t = 1; t <= 10 * n; t++) begin
      if (t > 1) @(negedge clk_in);
      if ((t - 1) % n == n / 2) bits[(t - 1) / n] = rx_line[idx];
      if (rx_done[idx] === 1'b1 && done_at < 0) done_at = t;
    end
    check("rx start bit", 32'(bits[0]), 32'd0);
    check("rx stop bit", 32'(bits[9]), 32'd1);
    data = bits[8:1];
  endtask

  task automatic accept_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk_in);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk_in);
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait for idle", 32'(ok), 32'd1);
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_0x55();
    int   cyc [9] = '{1, 20, 21, 40, 41, 60, 180, 181, 200};
    logic lvl [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_idle(10);
    accept_byte(8'h55);
    for (int c = 1; c <= 201; c++) begin
      @(negedge clk_in);
      for (int j = 0; j < 9; j++)
        if (cyc[j] == c) check($sformatf("0x55 tx_out cycle %0d", c), 32'(tx_out), 32'(lvl[j]));
      if (c == 199) check("0x55 tx_done cycle 199", 32'(tx_done), 32'd0);
      if (c == 200) check("0x55 tx_done cycle 200", 32'(tx_done), 32'd1);
      if (c == 200) check("0x55 tx_ready cycle 200", 32'(tx_ready), 32'd0);
      if (c == 201) check("0x55 tx_ready cycle 201", 32'(tx_ready), 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic samp [401];
    int   runs [$];
    int   exp_runs [4] = '{180, 21, 20, 180};
    int   len, second_start;
    logic cur;
    wait_idle(10);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk_in);
    #1;
    tx_data = 8'hFF;
    for (int c = 1; c <= 401; c++) begin
      @(negedge clk_in);
      samp[c - 1] = tx_out;
      if (c == 201) begin
        @(posedge clk_in);
        #1;
        tx_valid = 1'b0;
      end
    end
    cur = samp[0];
    len = 1;
    second_start = -1;
    for (int i = 1; i < 401; i++) begin
      if (samp[i] === cur) len++;
      else begin
        runs.push_back(len);
        cur = samp[i];
        len = 1;
        if (samp[i] === 1'b0 && second_start < 0) second_start = i;
      end
    end
    runs.push_back(len);
    check("b2b first start bit", 32'(samp[0]), 32'd0);
    check("b2b start-to-start cycles", second_start, 201);
    check("b2b run count", runs.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b2b run %0d length", i), (i < runs.size()) ? runs[i] : -1, exp_runs[i]);
  endtask

  task automatic test_busy_ignore();
    logic [7:0] d;
    int         done_at, lows;
    wait_idle(10);
    fork
      rx_decode(0, N, 20, d, done_at);
      begin
        accept_byte(8'h3C);
        repeat (49) @(posedge clk_in);
        #1;
        tx_data  = 8'hA3;
        tx_valid = 1'b1;
        @(posedge clk_in);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'h5A;
      end
    join
    check("busy-ignore decoded byte", 32'(d), 32'h3C);
    check("busy-ignore done cycle", done_at, 10 * N);
    wait_idle(10);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_in);
      if (tx_out !== 1'b1 || tx_ready !== 1'b1) lows++;
    end
    check("busy-ignore no second frame", lows, 0);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int         done_at;
    wait_idle(10);
    accept_byte(8'h81);
    repeat (94) @(posedge clk_in);
    #2;
    check("reset: line low before abort", 32'(tx_out), 32'd0);
    rst_n = 1'b0;
    #1;
    check("reset async tx_out", 32'(tx_out), 32'd1);
    check("reset async tx_ready", 32'(tx_ready), 32'd1);
    check("reset async tx_busy", 32'(tx_busy), 32'd0);
    check("reset async tx_done", 32'(tx_done), 32'd0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check("reset held: no tx_done", 32'(tx_done), 32'd0);
    end
    fork
      rx_decode(0, N, 20, d, done_at);
      begin
        @(posedge clk_in);
        #2;
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
        check("first edge after reset accepts", 32'(tx_ready), 32'd0);
        tx_valid = 1'b0;
      end
    join
    check("post-reset decoded byte", 32'(d), 32'h81);
    check("post-reset done cycle", done_at, 10 * N);
  endtask

  task automatic test_small_n();
    logic [7:0] d;
    int         done_at;
    fork
      rx_decode(1, N_SMALL, 20, d, done_at);
      begin
        @(posedge clk_in);
        #1;
        tx_data_s  = 8'hC4;
        tx_valid_s = 1'b1;
        @(posedge clk_in);
        #1;
        tx_valid_s = 1'b0;
      end
    join
    check("N=2 decoded byte", 32'(d), 32'hC4);
    check("N=2 frame length", done_at, 10 * N_SMALL);
  endtask

  // 0xC4 LSB first is 0,0,1,0,...: start plus two zero bits form one 3*N low run, then N high.
  task automatic test_big_n();
    int cnt;
    @(posedge clk_in);
    #1;
    tx_data_b  = 8'hC4;
    tx_valid_b = 1'b1;
    @(posedge clk_in);
    #1;
    tx_valid_b = 1'b0;
    @(negedge clk_in);
    check("N=16383 start edge", 32'(tx_out_b), 32'd0);
    cnt = 0;
    while (tx_out_b === 1'b0 && cnt < 4 * N_BIG) begin
      cnt++;
      @(negedge clk_in);
    end
    check("N=16383 start+bit0+bit1 low cycles", cnt, 3 * N_BIG);
    cnt = 0;
    while (tx_out_b === 1'b1 && cnt < 2 * N_BIG) begin
      cnt++;
      @(negedge clk_in);
    end
    check("N=16383 bit2 high cycles", cnt, N_BIG);
    check("N=16383 bit3 low", 32'(tx_out_b), 32'd0);
    #2;
    rst_n_b = 1'b0;
    #1;
    check("N=16383 async reset tx_out", 32'(tx_out_b), 32'd1);
    check("N=16383 async reset tx_ready", 32'(tx_ready_b), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    rst_n   = 1'b0;
    rst_n_s = 1'b0;
    rst_n_b = 1'b0;
    #1;
    check("reset tx_out", 32'(tx_out), 32'd1);
    check("reset tx_ready", 32'(tx_ready), 32'd1);
    check("reset tx_busy", 32'(tx_busy), 32'd0);
    check("reset tx_done", 32'(tx_done), 32'd0);
    #10;
    rst_n   = 1'b1;
    rst_n_s = 1'b1;
    rst_n_b = 1'b1;
    cmp_en  = 1'b1;
    @(posedge clk_in);
    #1;
    fork
      test_big_n();
      begin
        test_0x55();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        test_small_n();
        wait_idle(10 * N + 10);
      end
    join
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
